// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared types and helpers for the decoder scan controller: FSM states,
// default geometry and the set-bit search used to step through the channel mask.
package decoder_scan_ctrl_pkg;

  localparam int K_DEF       = 6;
  localparam int DWELL_W_DEF = 8;
  localparam int MAX_K       = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // Lowest set bit of m strictly above cur among the low 2**k bits; -1 if none.
  // Pass cur = -1 to search from the bottom.
  function automatic int next_set_bit(input logic [2**MAX_K-1:0] m, input int k, input int cur);
    int r;
    r = -1;
    for (int i = 2**MAX_K-1; i >= 0; i--) begin
      if ((i < (1 << k)) && m[i] && (i > cur)) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/decoder_scan_ctrl_bin2onehot.sv
// Binary index to one-hot decoder with an enable; output is all-zero when disabled.
module bin2onehot #(
  parameter int K = 6
) (
  input  logic           en,
  input  logic [K-1:0]   idx,
  output logic [2**K-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scans the enabled channels of a captured mask, holding each for dwell+1 cycles
// and driving a one-hot select bus that is only live while the scan is active.
module decoder_scan_ctrl
  import decoder_scan_ctrl_pkg::*;
#(
  parameter int K       = K_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  input  logic [2**K-1:0]    mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic               busy,
  output logic               done,
  output logic               ch_strobe,
  output logic [K-1:0]       sel_idx,
  output logic [2**K-1:0]    io_out
);

  localparam int N = 2**K;

  state_e              state;
  logic [N-1:0]        mask_q;
  logic [DWELL_W-1:0]  dwell_q;
  logic [DWELL_W-1:0]  cnt;
  logic                loop_q;

  logic [2**MAX_K-1:0] mask_in_ext;
  logic [2**MAX_K-1:0] mask_q_ext;
  int                  first_in;
  int                  first_q;
  int                  next_q;

  // The first channel comes from the live mask so ACTIVE starts one cycle after start.
  always_comb begin
    mask_in_ext          = '0;
    mask_in_ext[N-1:0]   = mask;
    mask_q_ext           = '0;
    mask_q_ext[N-1:0]    = mask_q;
    first_in = next_set_bit(mask_in_ext, K, -1);
    first_q  = next_set_bit(mask_q_ext, K, -1);
    next_q   = next_set_bit(mask_q_ext, K, int'(sel_idx));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ch_strobe <= 1'b0;
      sel_idx   <= '0;
      mask_q    <= '0;
      dwell_q   <= '0;
      loop_q    <= 1'b0;
      cnt       <= '0;
    end else begin
      done      <= 1'b0;
      ch_strobe <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mask_q  <= mask;
            dwell_q <= dwell;
            loop_q  <= loop_en;
            if (first_in < 0) begin
              state <= ST_FINISH;
              done  <= 1'b1;
            end else begin
              state     <= ST_ACTIVE;
              busy      <= 1'b1;
              ch_strobe <= 1'b1;
              sel_idx   <= K'(first_in);
              cnt       <= dwell;
            end
          end
        end
        ST_ACTIVE: begin
          // Abort wins over dwell expiry; sel_idx is left where it was.
          if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
          end else if (next_q >= 0) begin
            sel_idx   <= K'(next_q);
            cnt       <= dwell_q;
            ch_strobe <= 1'b1;
          end else if (loop_q) begin
            sel_idx   <= K'(first_q);
            cnt       <= dwell_q;
            ch_strobe <= 1'b1;
          end else begin
            state <= ST_FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  bin2onehot #(.K(K)) u_dec (
    .en     (busy),
    .idx    (sel_idx),
    .onehot (io_out)
  );

endmodule
